// File: rtl/bch_p32_t8_pkg.sv
// Shared constants for the t=8, GF(2^13), 32-bit-parallel BCH code.
// G_POLY is derived at elaboration from the field, so it always matches PRIM_POLY.
package bch_p32_t8_pkg;

  localparam int GF_M     = 13;
  localparam int T        = 8;
  localparam int PAR_BITS = 104;
  localparam int WORD_W   = 32;

  // x^13 + x^4 + x^3 + x + 1
  localparam logic [GF_M:0] PRIM_POLY = 14'h201B;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  function automatic logic [GF_M-1:0] gf_mul(input logic [GF_M-1:0] a, input logic [GF_M-1:0] b);
    logic [GF_M-1:0] p;
    p = '0;
    for (int i = GF_M - 1; i >= 0; i--) begin
      p = {p[GF_M-2:0], 1'b0} ^ (p[GF_M-1] ? PRIM_POLY[GF_M-1:0] : '0);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  // Product of (x + beta) over every conjugate of alpha^1,3,...,2T-1.
  function automatic logic [PAR_BITS:0] gen_poly();
    logic [PAR_BITS:0][GF_M-1:0] g;
    logic [GF_M-1:0]             beta;
    logic [PAR_BITS:0]           res;
    g    = '0;
    g[0] = 13'd1;
    for (int i = 1; i < 2 * T; i += 2) begin
      beta = 13'd1;
      for (int k = 0; k < i; k++) beta = gf_mul(beta, 13'd2);
      for (int j = 0; j < GF_M; j++) begin
        for (int d = PAR_BITS; d > 0; d--) g[d] = g[d-1] ^ gf_mul(g[d], beta);
        g[0] = gf_mul(g[0], beta);
        beta = gf_mul(beta, beta);
      end
    end
    for (int d = 0; d <= PAR_BITS; d++) res[d] = g[d][0];
    return res;
  endfunction

  localparam logic [PAR_BITS:0] G_POLY = gen_poly();

endpackage

// File: rtl/bch_encoder_p32_t8_if.sv
// Word-stream bundle between a message source, the BCH encoder and the codeword sink.
interface bch_encoder_p32_t8_if;
  import bch_p32_t8_pkg::*;

  logic              start;
  logic [WORD_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic [WORD_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic              busy;

  modport master (
    output start, din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, dout_last, busy
  );

  modport slave (
    input  start, din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, dout_last, busy
  );

endinterface

// File: rtl/bch_enc_step_p32.sv
// Combinational 32-bit remainder update: 32 bit-serial LFSR stages, MSB of din first.
module bch_enc_step_p32
  import bch_p32_t8_pkg::*;
(
  input  logic [PAR_BITS-1:0] rem,
  input  logic [WORD_W-1:0]   din,
  output logic [PAR_BITS-1:0] rem_next
);

  logic [PAR_BITS-1:0] r;
  logic                fb;

  always_comb begin
    r  = rem;
    fb = 1'b0;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      fb = din[i] ^ r[PAR_BITS-1];
      r  = {r[PAR_BITS-2:0], 1'b0} ^ ({PAR_BITS{fb}} & G_POLY[PAR_BITS-1:0]);
    end
    rem_next = r;
  end

endmodule

// File: rtl/bch_encoder_p32_t8.sv
// Systematic BCH t=8 encoder: MSG_WORDS data words pass through, then 4 parity words (BCH_ENC_PARITY_INV_EN inverts parity).
// Latency: an accepted word is on dout from the accepting edge; parity follows with no bubble.
// Backpressure: din_ready only while the single output register is free or draining this cycle.
module bch_encoder_p32_t8
  import bch_p32_t8_pkg::*;
#(
  parameter int MSG_WORDS = 128,
  parameter int PAR_WORDS = 4
) (
  input logic clk,
  input logic reset,
  bch_encoder_p32_t8_if.slave bus
);

  state_t              state;
  logic [PAR_BITS-1:0] rem;
  logic [PAR_BITS-1:0] rem_next;
  logic [PAR_BITS-1:0] rem_out;
  logic [7:0]          word_cnt;
  logic [1:0]          par_cnt;
  logic [WORD_W-1:0]   par_word;
  logic [WORD_W-1:0]   dout_q;
  logic                dout_valid_q;
  logic                dout_last_q;
  logic                out_free;
  logic                din_acc;

  bch_enc_step_p32 u_step (
    .rem      (rem),
    .din      (bus.din),
    .rem_next (rem_next)
  );

`ifdef BCH_ENC_PARITY_INV_EN
  assign rem_out = ~rem;
`else
  assign rem_out = rem;
`endif

  // Last word keeps the low 8 remainder bits left-aligned; the 24 pad bits are always zero.
  always_comb begin
    par_word = '0;
    case (par_cnt)
      2'd0: par_word = rem_out[103:72];
      2'd1: par_word = rem_out[71:40];
      2'd2: par_word = rem_out[39:8];
      2'd3: par_word = {rem_out[7:0], 24'h0};
      default: par_word = '0;
    endcase
  end

  assign out_free       = ~dout_valid_q | bus.dout_ready;
  assign din_acc        = bus.din_valid & bus.din_ready;
  assign bus.din_ready  = (state == DATA) & out_free;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_last  = dout_last_q;
  assign bus.busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rem          <= '0;
      word_cnt     <= '0;
      par_cnt      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else begin
      // Drain first; a load below in the same cycle overrides it.
      if (dout_valid_q && bus.dout_ready) begin
        dout_valid_q <= 1'b0;
        dout_last_q  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            rem      <= '0;
            word_cnt <= '0;
            par_cnt  <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (din_acc) begin
            rem          <= rem_next;
            dout_q       <= bus.din;
            dout_valid_q <= 1'b1;
            dout_last_q  <= 1'b0;
            word_cnt     <= word_cnt + 8'd1;
            if (word_cnt == 8'(MSG_WORDS - 1)) begin
              par_cnt <= '0;
              state   <= PARITY;
            end
          end
        end
        PARITY: begin
          if (out_free) begin
            dout_q       <= par_word;
            dout_valid_q <= 1'b1;
            dout_last_q  <= (par_cnt == 2'(PAR_WORDS - 1));
            par_cnt      <= par_cnt + 2'd1;
            if (par_cnt == 2'(PAR_WORDS - 1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
